cdb_arbiter: RTL

- Consumer end of the functional-unit result handshake (valid_out / yumi_in / CDB_packet_t out) used by divide and the other execute units.
- Collects finished results from NUM_FU functional units and grants one per cycle, round-robin.
- The granted result is broadcast on the common data bus as a registered one-cycle pulse to the ROB and reservation stations.
- A commit-side request has absolute priority over every functional unit.

---
 rtl/cdb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result per cycle onto a registered broadcast.
// The commit stage outranks every functional unit; functional units are served round-robin.
package cdb_pkg;
    typedef struct packed {
        logic        from_commit;
        logic [5:0]  dest_ROB_entry;
        logic [31:0] result;
    } CDB_packet_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_FU-1:0] fu_valid,
    input  CDB_packet_t       fu_pkt [NUM_FU],
    output logic [NUM_FU-1:0] fu_yumi,
    input  logic              commit_valid,
    input  CDB_packet_t       commit_pkt,
    output logic              commit_yumi,
    input  logic              flush,
    output logic              cdb_valid,
    output CDB_packet_t       cdb_out,
    output logic [PTR_W-1:0]  grant_idx
);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] grant_idx_q;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] sel;
    logic             fu_grant;
    logic             cdb_valid_q;
    CDB_packet_t      cdb_out_q;
    CDB_packet_t      grant_pkt;

    // Scan from rr_ptr upward; the first requester found wins.
    always_comb begin
        fu_yumi     = '0;
        commit_yumi = 1'b0;
        fu_grant    = 1'b0;
        sel         = '0;
        cand        = '0;
        if (reset && !flush) begin
            if (commit_valid) begin
                commit_yumi = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_FU; k++) begin
                    cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_FU);
                    if (!fu_grant && fu_valid[cand]) begin
                        fu_grant = 1'b1;
                        sel      = cand;
                    end
                end
                fu_yumi[sel] = fu_grant;
            end
        end
    end

    always_comb begin
        grant_pkt = commit_yumi ? commit_pkt : fu_pkt[sel];
        rr_ptr_d  = PTR_W'((32'(sel) + 1) % NUM_FU);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            cdb_valid_q <= commit_yumi | fu_grant;
            if (commit_yumi || fu_grant) begin
                cdb_out_q <= grant_pkt;
            end
            // Commit grants leave the round-robin position untouched.
            if (fu_grant) begin
                rr_ptr_q    <= rr_ptr_d;
                grant_idx_q <= sel;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_out   = cdb_out_q;
    assign grant_idx = grant_idx_q;

endmodule
